// File: rtl/ram8_bank.sv
// ram8_bank: eight-word register file, WIDTH bits per word.
//
// This is the leaf storage stage of the RAM64/RAM512 hierarchy.
// - The load strobe is decoded one-hot by address into eight word registers.
// - A registered 8:1 read mux drives `out`.
// - A built-in clear sequencer zeroes all eight words over eight cycles.
//
// Optional feature (compile-time macro RAM8_PARITY_EN):
//   Each word carries a stored parity bit, and `parity_err` flags a mismatch
//   on the registered read. When the macro is undefined, `parity_err` is
//   tied to 0 and `err_inject` is ignored.
//
// Ports:
//   clk        - single clock; all state changes on the rising edge
//   reset_n    - asynchronous, active-low reset
//   in         - write data (WIDTH bits)
//   load       - write strobe for word[address]
//   address    - word select 0..7
//   clear      - start an 8-cycle zeroing sweep
//   err_inject - invert the stored parity bit on this write (parity build only)
//   out        - registered read data, 1-cycle latency
//   busy       - high while the clear sweep is active
//   parity_err - registered parity mismatch flag aligned with `out`
//
// Handshake: there is no valid/ready pair.
// - `load` and `clear` are single-cycle strobes, sampled on every rising edge.
// - While `busy` is high, both strobes are ignored; the caller must wait for
//   `busy` low before issuing further writes or clears.
module ram8_bank #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  input  logic             clear,
  input  logic             err_inject,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             parity_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [WIDTH-1:0] mem_q [8];
  logic [WIDTH-1:0] out_q;
  logic             wr_en;

  // A clear request takes priority over a coincident load, and that load is
  // dropped.
  assign wr_en = (state_q == IDLE) && load && !clear;

  // Next-state logic for the clear sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = SWEEP;
          idx_d   = 3'd0;
        end
      end
      SWEEP: begin
        // The 7 -> 0 wrap of idx coincides with the exit back to IDLE.
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Word storage and registered read. Reads are write-first: a write and a
  // read to the same address on the same edge return the new data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) mem_q[i] <= '0;
      out_q <= '0;
    end else if (state_q == SWEEP) begin
      mem_q[idx_q] <= '0;
      out_q        <= '0;
    end else if (wr_en) begin
      mem_q[address] <= in;
      out_q          <= in;
    end else begin
      out_q <= mem_q[address];
    end
  end

  assign out  = out_q;
  assign busy = (state_q == SWEEP);

`ifdef RAM8_PARITY_EN
  logic [7:0] par_q;
  logic       perr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_q  <= '0;
      perr_q <= 1'b0;
    end else if (state_q == SWEEP) begin
      par_q[idx_q] <= 1'b0;
      perr_q       <= 1'b0;
    end else if (wr_en) begin
      par_q[address] <= (^in) ^ err_inject;
      // On a write-first bypass the stored and recomputed parity differ
      // exactly by the injected flip.
      perr_q         <= err_inject;
    end else begin
      perr_q <= (^mem_q[address]) != par_q[address];
    end
  end

  assign parity_err = perr_q;
`else
  logic unused_err_inject;
  assign unused_err_inject = err_inject;
  assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_ram8_bank.sv
// Directed self-checking bench for ram8_bank.
module tb_ram8_bank;

  localparam int WIDTH = 16;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] in;
  logic             load;
  logic [2:0]       address;
  logic             clear;
  logic             err_inject;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             parity_err;

  int tests_run;
  int tests_failed;

  ram8_bank #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in         (in),
    .load       (load),
    .address    (address),
    .clear      (clear),
    .err_inject (err_inject),
    .out        (out),
    .busy       (busy),
    .parity_err (parity_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [WIDTH-1:0] d,
                          input logic e);
    address    = a;
    in         = d;
    load       = 1'b1;
    err_inject = e;
    tick();
    load       = 1'b0;
    err_inject = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a,
                            input logic [WIDTH-1:0] exp);
    address = a;
    load    = 1'b0;
    tick();
    check_eq(tag, {16'h0, out}, {16'h0, exp});
    check_eq({tag, "_perr"}, {31'h0, parity_err}, 32'h0);
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 8; i++) read_check(tag, i[2:0], '0);
  endtask

  // Stimulus
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    in           = '0;
    load         = 1'b0;
    address      = 3'd0;
    clear        = 1'b0;
    err_inject   = 1'b0;

    // 1. Reset state, then async reset mid-run
    #12;
    check_eq("rst_out", {16'h0, out}, 32'h0);
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_perr", {31'h0, parity_err}, 32'h0);
    reset_n = 1'b1;
    tick();
    do_write(3'd3, 16'h7E7E, 1'b0);
    check_eq("pre_rst_out", {16'h0, out}, 32'h7E7E);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst_out", {16'h0, out}, 32'h0);
    check_eq("async_rst_busy", {31'h0, busy}, 32'h0);
    #10 reset_n = 1'b1;
    read_all_zero("after_rst");

    // 2. Write A0+i to each word, then read back
    for (int i = 0; i < 8; i++) do_write(i[2:0], 16'h00A0 + 16'(i), 1'b0);
    for (int i = 0; i < 8; i++) read_check("rd_a0", i[2:0], 16'h00A0 + 16'(i));

    // 3. Write-first bypass on address 5
    do_write(3'd5, 16'h1234, 1'b0);
    check_eq("bypass_out", {16'h0, out}, 32'h1234);
    read_check("rd5_after", 3'd5, 16'h1234);
    read_check("rd4_kept", 3'd4, 16'h00A4);

    // 4. Clear wins over load; load during sweep ignored; busy high 8 cycles
    clear   = 1'b1;
    load    = 1'b1;
    address = 3'd2;
    in      = 16'hFFFF;
    tick();
    clear   = 1'b0;
    check_eq("sweep_busy_1", {31'h0, busy}, 32'h1);
    address = 3'd3;
    in      = 16'h5555;
    for (int k = 2; k <= 8; k++) begin
      tick();
      check_eq("sweep_busy", {31'h0, busy}, 32'h1);
      check_eq("sweep_out", {16'h0, out}, 32'h0);
    end
    load = 1'b0;
    tick();
    check_eq("sweep_done_busy", {31'h0, busy}, 32'h0);
    read_all_zero("after_clear");

    // 5. Reset during sweep cycle 4, then a normal write
    do_write(3'd1, 16'h1111, 1'b0);
    do_write(3'd7, 16'h7777, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check_eq("mid_sweep_busy", {31'h0, busy}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("sweep_rst_busy", {31'h0, busy}, 32'h0);
    check_eq("sweep_rst_out", {16'h0, out}, 32'h0);
    #10 reset_n = 1'b1;
    tick();
    check_eq("sweep_not_resumed", {31'h0, busy}, 32'h0);
    read_all_zero("after_sweep_rst");
    do_write(3'd4, 16'hBEEF, 1'b0);
    read_check("rd4_new", 3'd4, 16'hBEEF);
    read_check("rd1_zero", 3'd1, 16'h0000);

    // 6. Parity
    do_write(3'd6, 16'h0003, 1'b1);
`ifdef RAM8_PARITY_EN
    check_eq("perr_bypass", {31'h0, parity_err}, 32'h1);
    address = 3'd6;
    tick();
    check_eq("perr_read_bad", {31'h0, parity_err}, 32'h1);
    check_eq("perr_read_out", {16'h0, out}, 32'h0003);
    do_write(3'd6, 16'h0003, 1'b0);
    check_eq("perr_bypass_ok", {31'h0, parity_err}, 32'h0);
    read_check("perr_read_ok", 3'd6, 16'h0003);
`else
    check_eq("perr_tied_bypass", {31'h0, parity_err}, 32'h0);
    read_check("perr_tied_read", 3'd6, 16'h0003);
`endif

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
